// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold one modulo-radix digit.
  function automatic int digit_width(input int radix);
    return $clog2(radix);
  endfunction

endpackage

// File: rtl/updown_digit.sv
// One modulo-RADIX digit with parallel load (clamped) and single-step up/down.
module updown_digit
  import counter_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = digit_width(RADIX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          up,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  output logic [DW-1:0] value,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MAX = DW'(RADIX - 1);

  logic [DW-1:0] value_reg, value_next;

  assign value   = value_reg;
  assign at_max  = (value_reg == MAX);
  assign at_zero = (value_reg == '0);

  always_comb begin
    value_next = value_reg;
    if (load) begin
      // Out-of-range load digits clamp so the digit never exceeds RADIX-1.
      value_next = (load_digit > MAX) ? MAX : load_digit;
    end else if (step) begin
      if (up == DIR_UP) value_next = at_max  ? '0  : value_reg + DW'(1);
      else              value_next = at_zero ? MAX : value_reg - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value_reg <= '0;
    else       value_reg <= value_next;
  end

endmodule

// File: rtl/cascaded_updown_counter.sv
// DIGITS cascaded modulo-RADIX digits with single-cycle carry/borrow lookahead,
// load, enable, wrap/saturate mode, combinational tc and registered ovf pulse.
module cascaded_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int SATURATE = MODE_WRAP,
  localparam int DW      = digit_width(RADIX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 ovf
);

  logic [DIGITS-1:0] at_max, at_zero, chain, digit_step;
  logic              boundary, hold, ovf_reg;

  assign boundary = (up == DIR_UP) ? (&at_max) : (&at_zero);
  assign hold     = (SATURATE == MODE_SAT) && boundary;
  assign tc       = boundary;
  assign ovf      = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // AND-prefix of lower-digit terminal states: all carries resolve this cycle.
      if (gi == 0) begin : g_first
        assign chain[gi] = en;
      end else begin : g_rest
        assign chain[gi] = chain[gi-1] &
                           ((up == DIR_UP) ? at_max[gi-1] : at_zero[gi-1]);
      end

      assign digit_step[gi] = chain[gi] & ~hold;

      updown_digit #(
        .RADIX (RADIX),
        .DW    (DW)
      ) u_digit (
        .clk        (clk),
        .reset      (reset),
        .step       (digit_step[gi]),
        .up         (up),
        .load       (load),
        .load_digit (load_val[gi*DW +: DW]),
        .value      (count[gi*DW +: DW]),
        .at_max     (at_max[gi]),
        .at_zero    (at_zero[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)     ovf_reg <= 1'b0;
    else if (load) ovf_reg <= 1'b0;
    else           ovf_reg <= en & boundary;
  end

endmodule

// File: tb/tb_cascaded_updown_counter.sv
// Randomized + directed bench: wrap and saturate instances share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_cascaded_updown_counter;

  localparam int DIGITS = 2;
  localparam int RADIX  = 10;
  localparam int DW     = 4;
  localparam int MAXV   = 99;

  logic              clk = 1'b0;
  logic              reset, en, up, load;
  logic [DIGITS*DW-1:0] load_val;
  logic [DIGITS*DW-1:0] count_w, count_s;
  logic              tc_w, tc_s, ovf_w, ovf_s;

  int tests = 0;
  int fails = 0;
  bit chk   = 1'b0;

  int mval_w = 0, mval_s = 0;
  bit movf_w = 1'b0, movf_s = 1'b0;

  always #5 clk = ~clk;

  cascaded_updown_counter #(.DIGITS(DIGITS), .RADIX(RADIX), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w));

  cascaded_updown_counter #(.DIGITS(DIGITS), .RADIX(RADIX), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s));

  function automatic logic [7:0] pack(input int v);
    logic [7:0] p;
    p[3:0] = 4'(v % 10);
    p[7:4] = 4'(v / 10);
    return p;
  endfunction

  function automatic int clamp_load(input logic [7:0] lv);
    int lo, hi;
    lo = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
    hi = (int'(lv[7:4]) > 9) ? 9 : int'(lv[7:4]);
    return hi * 10 + lo;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter value as a plain integer 0..99.
  task automatic model_step(inout int v, inout bit o, input bit sat);
    if (reset) begin
      v = 0; o = 0;
    end else if (load) begin
      v = clamp_load(load_val); o = 0;
    end else if (en) begin
      if (up) begin
        o = (v == MAXV);
        v = (v == MAXV) ? (sat ? v : 0) : v + 1;
      end else begin
        o = (v == 0);
        v = (v == 0) ? (sat ? v : MAXV) : v - 1;
      end
    end else begin
      o = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(mval_w, movf_w, 1'b0);
    model_step(mval_s, movf_s, 1'b1);
  end

  always @(negedge clk) begin
    if (chk) begin
      check("cmp_count_wrap", 32'(count_w), 32'(pack(mval_w)));
      check("cmp_ovf_wrap",   32'(ovf_w),   32'(movf_w));
      check("cmp_tc_wrap",    32'(tc_w),    32'(up ? (mval_w == MAXV) : (mval_w == 0)));
      check("cmp_count_sat",  32'(count_s), 32'(pack(mval_s)));
      check("cmp_ovf_sat",    32'(ovf_s),   32'(movf_s));
      check("cmp_tc_sat",     32'(tc_s),    32'(up ? (mval_s == MAXV) : (mval_s == 0)));
    end
  end

  task automatic tick(input bit r, input bit l, input logic [7:0] lv, input bit e, input bit u);
    reset = r; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit r, l, e, u;
    logic [7:0] lv;

    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;

    // Reset and tc
    tick(1, 0, 8'h00, 0, 1);
    chk = 1'b1;
    check("reset_count", 32'(count_w), 32'h00);
    check("reset_ovf",   32'(ovf_w),   32'h0);
    check("reset_tc_up", 32'(tc_w),    32'h0);
    up = 1'b0; #1;
    check("reset_tc_down", 32'(tc_w), 32'h1);

    // Up wrap
    for (int i = 0; i < 99; i++) tick(0, 0, 8'h00, 1, 1);
    check("up_99_count", 32'(count_w), 32'h99);
    check("up_99_tc",    32'(tc_w),    32'h1);
    tick(0, 0, 8'h00, 1, 1);
    check("up_wrap_count", 32'(count_w), 32'h00);
    check("up_wrap_ovf",   32'(ovf_w),   32'h1);
    tick(0, 0, 8'h00, 0, 1);
    check("up_wrap_ovf_drop", 32'(ovf_w), 32'h0);

    // Down wrap with digit-1 borrow on x0 only
    tick(0, 1, 8'h47, 0, 0);
    check("load_47", 32'(count_w), 32'h47);
    for (int i = 0; i < 7; i++) tick(0, 0, 8'h00, 1, 0);
    check("down_40", 32'(count_w), 32'h40);
    tick(0, 0, 8'h00, 1, 0);
    check("down_39", 32'(count_w), 32'h39);
    for (int i = 0; i < 39; i++) tick(0, 0, 8'h00, 1, 0);
    check("down_00", 32'(count_w), 32'h00);
    tick(0, 0, 8'h00, 1, 0);
    check("down_wrap_count", 32'(count_w), 32'h99);
    check("down_wrap_ovf",   32'(ovf_w),   32'h1);

    // Saturate instance
    tick(0, 1, 8'h98, 0, 1);
    tick(0, 0, 8'h00, 1, 1);
    check("sat1_count", 32'(count_s), 32'h99);
    check("sat1_ovf",   32'(ovf_s),   32'h0);
    tick(0, 0, 8'h00, 1, 1);
    check("sat2_count", 32'(count_s), 32'h99);
    check("sat2_ovf",   32'(ovf_s),   32'h1);
    tick(0, 0, 8'h00, 1, 1);
    check("sat3_count", 32'(count_s), 32'h99);
    check("sat3_ovf",   32'(ovf_s),   32'h1);
    tick(0, 0, 8'h00, 1, 0);
    check("sat_down_count", 32'(count_s), 32'h98);
    check("sat_down_ovf",   32'(ovf_s),   32'h0);

    // Load clamp and priority
    tick(0, 1, 8'hAF, 1, 1);
    check("clamp_count", 32'(count_w), 32'h99);
    check("clamp_ovf",   32'(ovf_w),   32'h0);
    tick(1, 1, 8'h55, 1, 1);
    check("reset_over_load", 32'(count_w), 32'h00);

    // Direction flip
    tick(0, 1, 8'h09, 0, 1);
    tick(0, 0, 8'h00, 1, 1);
    check("flip_up_count", 32'(count_w), 32'h10);
    check("flip_up_ovf",   32'(ovf_w),   32'h0);
    tick(0, 0, 8'h00, 1, 0);
    check("flip_down_count", 32'(count_w), 32'h09);
    check("flip_down_ovf",   32'(ovf_w),   32'h0);

    // Randomized run against the model
    u = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        default: lv = 8'($urandom);
      endcase
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) u = ~u;
      tick(r, l, lv, e, u);
    end

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
